// File: rtl/mult_pkg.sv
// mult_pkg: shared types and defaults for the multiply issue controller.
package mult_pkg;
    typedef enum logic [1:0] {MUL = 2'b00, SMULH = 2'b01, UMULH = 2'b10, RSVD = 2'b11} mult_mode_t;
    typedef enum logic [2:0] {IDLE, START, WAIT, DONE, DRAIN} issue_state_t;
    localparam int DEF_TIMEOUT = 200;
endpackage

// File: rtl/mult_watchdog.sv
// mult_watchdog: saturating cycle counter; expired holds once TIMEOUT is reached.
module mult_watchdog
    import mult_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] count;
    assign expired = count == CW'(TIMEOUT);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (en && !expired)
            count <= count + CW'(1);
    end
endmodule

// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: EX-stage issue/writeback controller for the iterative multiplier.
// The watchdog also runs during START, so DONE lands exactly TIMEOUT cycles after WAIT entry.
module mult_issue_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int RD_W    = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_is_mult,
    input  logic [1:0]       ex_mode,
    input  logic [WIDTH-1:0] ex_rn,
    input  logic [WIDTH-1:0] ex_rm,
    input  logic [RD_W-1:0]  ex_rd,
    input  logic             flush,
    output logic [1:0]       mult_mode,
    output logic [WIDTH-1:0] multiplicand,
    output logic [WIDTH-1:0] multiplier,
    output logic             start,
    input  logic [WIDTH-1:0] result,
    input  logic             ready,
    output logic             stall,
    output logic             wb_valid,
    output logic [RD_W-1:0]  wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic             err
);
    issue_state_t state, next;
    logic issue, active, expired, timeout_hit;

    assign issue       = ex_valid && ex_is_mult && !flush;
    assign active      = state inside {START, WAIT, DRAIN};
    assign start       = state == START;
    assign wb_valid    = state == DONE && !flush;
    assign stall       = (state == IDLE || state == DRAIN) ? issue : (state == START || state == WAIT);
    assign timeout_hit = expired && !ready && ((state == WAIT && !flush) || state == DRAIN);

    mult_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (!active),
        .en      (active),
        .expired (expired)
    );

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = !issue ? IDLE : (mult_mode_t'(ex_mode) == RSVD) ? DONE : START;
            START:   next = flush ? DRAIN : WAIT;
            WAIT:    next = flush ? DRAIN : (ready || expired) ? DONE : WAIT;
            DONE:    next = IDLE;
            DRAIN:   next = (ready || expired) ? IDLE : DRAIN;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            mult_mode    <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
            wb_rd        <= '0;
            wb_data      <= '0;
            err          <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && issue) begin
                mult_mode    <= ex_mode;
                multiplicand <= ex_rn;
                multiplier   <= ex_rm;
                wb_rd        <= ex_rd;
                wb_data      <= '0;
            end
            if (state == WAIT && !flush && ready)
                wb_data <= result;
            if (timeout_hit)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mult_issue_ctrl.sv
// tb_mult_issue_ctrl: directed bench with a small iterative-multiplier model (3-cycle countdown).
module tb_mult_issue_ctrl;
    localparam int W = 8, T = 6, LAT = 3;

    logic clk = 1'b0, reset = 1'b1;
    logic ex_valid, ex_is_mult, flush, start, ready, stall, wb_valid, err;
    logic [1:0] ex_mode, mult_mode;
    logic [W-1:0] ex_rn, ex_rm, multiplicand, multiplier, result, wb_data;
    logic [4:0] ex_rd, wb_rd;
    logic hang = 1'b0, busy;
    logic [3:0] cnt;
    int n_cmp = 0, n_bad = 0;

    mult_issue_ctrl #(.WIDTH(W), .TIMEOUT(T), .RD_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_is_mult   (ex_is_mult),
        .ex_mode      (ex_mode),
        .ex_rn        (ex_rn),
        .ex_rm        (ex_rm),
        .ex_rd        (ex_rd),
        .flush        (flush),
        .mult_mode    (mult_mode),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .start        (start),
        .result       (result),
        .ready        (ready),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] prod(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] u;
        logic signed [2*W-1:0] s;
        u = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        s = $signed(a) * $signed(b);
        return m == 2'b00 ? u[W-1:0] : m == 2'b01 ? s[2*W-1:W] : u[2*W-1:W];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready <= 1'b0; busy <= 1'b0; cnt <= '0; result <= '0;
        end else if (start) begin
            ready <= 1'b0; busy <= 1'b1; cnt <= 4'(LAT);
            result <= prod(mult_mode, multiplicand, multiplier);
        end else if (busy) begin
            if (cnt == 4'd1) begin
                ready <= !hang; busy <= 1'b0;
            end else
                cnt <= cnt - 4'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one instruction at a negedge, hold it while stalled, then check the writeback pulse.
    task automatic do_mul(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] rd, input logic [W-1:0] exp_d, input int exp_starts,
                          input int exp_lat, input string tag);
        int starts, lat;
        logic seen, hold_bad;
        ex_valid = 1'b1; ex_is_mult = 1'b1; ex_mode = m; ex_rn = a; ex_rm = b; ex_rd = rd;
        #1 check({tag, ".stall_issue"}, 32'(stall), 1);
        starts = 0; lat = 0; seen = 1'b0; hold_bad = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (start) starts++;
            if (wb_valid) seen = 1'b1;
            else if (!stall) hold_bad = 1'b1;
        end
        ex_valid = 1'b0;
        check({tag, ".wb_seen"}, 32'(seen), 1);
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".starts"}, starts, exp_starts);
        check({tag, ".stall_hold"}, 32'(hold_bad), 0);
        check({tag, ".wb_data"}, 32'(wb_data), 32'(exp_d));
        check({tag, ".wb_rd"}, 32'(wb_rd), 32'(rd));
        check({tag, ".stall_done"}, 32'(stall), 0);
        @(negedge clk);
        check({tag, ".pulse"}, 32'(wb_valid), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int wbs;
        ex_valid = 1'b0; ex_is_mult = 1'b0; ex_mode = '0; ex_rn = '0; ex_rm = '0; ex_rd = '0; flush = 1'b0;
        #3 reset = 1'b0;
        #9;
        check("rst.stall", 32'(stall), 0);
        check("rst.start", 32'(start), 0);
        check("rst.wb_valid", 32'(wb_valid), 0);
        check("rst.err", 32'(err), 0);
        check("rst.wb_data", 32'(wb_data), 0);
        check("rst.multiplicand", 32'(multiplicand), 0);
        check("rst.mult_mode", 32'(mult_mode), 0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);

        do_mul(2'b00, 8'd5, 8'd12, 5'd7, 8'h3C, 1, LAT + 3, "mul");
        do_mul(2'b10, 8'hFF, 8'hFF, 5'd3, 8'hFE, 1, LAT + 3, "umulh");
        do_mul(2'b01, 8'h80, 8'h02, 5'd4, 8'hFF, 1, LAT + 3, "smulh");
        do_mul(2'b11, 8'd9, 8'd9, 5'd2, 8'h00, 0, 1, "rsvd");

        ex_valid = 1'b1; ex_is_mult = 1'b1; ex_mode = 2'b00; ex_rn = 8'd4; ex_rm = 8'd4; flush = 1'b1;
        #1 check("idle_flush.stall", 32'(stall), 0);
        @(negedge clk);
        check("idle_flush.start", 32'(start), 0);
        check("idle_flush.stall2", 32'(stall), 0);
        ex_valid = 1'b0; flush = 1'b0;

        ex_valid = 1'b1; ex_rn = 8'd7; ex_rm = 8'd7; ex_rd = 5'd8;
        @(negedge clk);
        check("wait_flush.start", 32'(start), 1);
        @(negedge clk);
        flush = 1'b1; ex_valid = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        check("wait_flush.drain_stall", 32'(stall), 0);
        wbs = 0;
        repeat (10) begin
            @(negedge clk);
            if (wb_valid) wbs++;
        end
        check("wait_flush.no_wb", wbs, 0);
        check("wait_flush.err", 32'(err), 0);
        do_mul(2'b00, 8'd3, 8'd3, 5'd9, 8'h09, 1, LAT + 3, "after_flush");

        ex_valid = 1'b1; ex_is_mult = 1'b1; ex_mode = 2'b00; ex_rn = 8'd5; ex_rm = 8'd5; ex_rd = 5'd1;
        repeat (LAT + 3) @(negedge clk);
        check("done_flush.wb_before", 32'(wb_valid), 1);
        check("done_flush.data", 32'(wb_data), 32'h19);
        flush = 1'b1; ex_valid = 1'b0;
        #1 check("done_flush.suppressed", 32'(wb_valid), 0);
        @(negedge clk);
        flush = 1'b0;
        check("done_flush.after", 32'(wb_valid), 0);

        check("tmo.err_before", 32'(err), 0);
        hang = 1'b1;
        do_mul(2'b00, 8'd2, 8'd2, 5'd5, 8'h00, 1, T + 2, "tmo");
        check("tmo.err_set", 32'(err), 1);
        hang = 1'b0;
        do_mul(2'b00, 8'd6, 8'd7, 5'd6, 8'h2A, 1, LAT + 3, "post_tmo");
        check("tmo.err_sticky", 32'(err), 1);

        ex_valid = 1'b1; ex_is_mult = 1'b1; ex_mode = 2'b00; ex_rn = 8'd3; ex_rm = 8'd5; ex_rd = 5'd10;
        repeat (3) @(negedge clk);
        #2 ex_valid = 1'b0; reset = 1'b0;
        #1;
        check("midrst.stall", 32'(stall), 0);
        check("midrst.start", 32'(start), 0);
        check("midrst.wb_valid", 32'(wb_valid), 0);
        check("midrst.err", 32'(err), 0);
        @(negedge clk) reset = 1'b1;
        check("midrst.wb_data", 32'(wb_data), 0);
        @(negedge clk);

        do_mul(2'b00, 8'd2, 8'd3, 5'd1, 8'h06, 1, LAT + 3, "b2b_1");
        do_mul(2'b00, 8'd4, 8'd4, 5'd2, 8'h10, 1, LAT + 3, "b2b_2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
Execute-stage issue and writeback controller placed directly upstream of the iterative `multiplier`.
- Detects a multiply instruction in EX, registers its operands and mode, and pulses `start` to the multiplier.
- Stalls the pipeline until the multiplier reports `ready`, then delivers the result to writeback as a one-cycle pulse.
- Also handles flushes of an in-flight multiply and a watchdog timeout.

Parameters:
- WIDTH, 64: operand/result width; the bench uses 8.
- TIMEOUT, 200: maximum WAIT cycles before the error path is taken; must be ≥ 2.
- RD_W, 5: destination register index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_is_mult  in  1  EX instruction is MUL/SMULH/UMULH.
- ex_mode  in  2  multiply mode: 00 MUL (low half), 01 SMULH, 10 UMULH, 11 reserved.
- ex_rn  in  WIDTH  multiplicand operand.
- ex_rm  in  WIDTH  multiplier operand.
- ex_rd  in  RD_W  destination register.
- flush  in  1  cancel the current EX instruction.
- mult_mode  out  2  registered mode driven to the multiplier.
- multiplicand  out  WIDTH  registered operand.
- multiplier  out  WIDTH  registered operand.
- start  out  1  one-cycle start pulse.
- result  in  WIDTH  multiplier output.
- ready  in  1  multiplier result valid.
- stall  out  1  hold PC/IF/ID/EX.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_rd  out  RD_W  writeback destination.
- wb_data  out  WIDTH  writeback data.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, on reset=0):
  - State goes to IDLE.
  - All registered outputs, operand registers and the watchdog counter are cleared to 0.
  - `err` is cleared to 0; reset is the only way to clear it.
- States and transitions:
  - IDLE: on ex_valid & ex_is_mult & !flush, capture ex_rn/ex_rm/ex_mode/ex_rd and go to START. Mode 11 is not issued; it goes straight to DONE with wb_data=0.
  - START: `start`=1 for exactly this cycle; go to WAIT, or to DRAIN if flush.
  - WAIT: counter increments each cycle.
    - On ready=1, latch `result` into wb_data and go to DONE.
    - On flush, go to DRAIN.
    - On counter==TIMEOUT, set err, wb_data=0, go to DONE.
  - DONE: wb_valid=1 for one cycle, unless flush this cycle, which suppresses it combinationally. Always go to IDLE.
  - DRAIN: wait for ready or timeout, discard the result, go to IDLE. No wb_valid; err is still set on timeout.
- `stall`:
  - Combinational: 1 in IDLE when ex_valid & ex_is_mult & !flush.
  - 1 throughout START and WAIT.
  - 1 in DRAIN only if EX presents a new multiply.
  - 0 in DONE, so the instruction retires at the end of the DONE cycle.
- EX inputs are sampled only in IDLE, so the retiring instruction cannot re-trigger.
- Multiplier contract: `ready` is sampled only in WAIT/DRAIN. The multiplier drops ready the cycle after start and holds the result stable while ready=1.
- Latency: issue cycle in IDLE, then 1 (START), then N multiplier cycles, then 1 (DONE). Back-to-back multiplies have one IDLE gap.
- Widths:
  - Operands pass through unmodified.
  - wb_data is exactly WIDTH bits; the high/low selection is done by the multiplier per mode.
  - The counter is clog2(TIMEOUT+1) bits and saturates at TIMEOUT.
- Flush:
  - In IDLE: the request is ignored.
  - Simultaneous ready and flush in WAIT: flush wins, result discarded.
- Reset mid-operation: the block returns immediately to IDLE; the multiplier is reset by the same line.

Decomposition:
- Shared package mult_pkg:
  - mult_mode_t enum (MUL, SMULH, UMULH, RSVD).
  - issue_state_t enum (IDLE, START, WAIT, DONE, DRAIN).
  - Default TIMEOUT constant.
- One sub-module, mult_watchdog: clear/enable inputs, saturating counter, `expired` output, parameterised by TIMEOUT.
- FSM and operand registers stay in mult_issue_ctrl.

Test Plan:
- Basic MUL (WIDTH=8): issue MUL 5×12 → start pulses once, stall high until DONE, wb_valid one cycle, wb_data=0x3C, wb_rd matches.
- UMULH and SMULH: UMULH 0xFF×0xFF → wb_data=0xFE; SMULH 0x80×0x02 → wb_data=0xFF.
- Flush: flush during WAIT → no wb_valid, state returns to IDLE after ready; next MUL 3×3 → wb_data=0x09.
- Timeout: multiplier model never raises ready → err=1 and wb_valid with 0x00 exactly TIMEOUT cycles after WAIT entry; err stays 1 until reset.
- Reset mid-op: drive reset=0 asynchronously during WAIT → stall, start, wb_valid and err are 0 before the next clock edge.
- Back-to-back: two consecutive MULs 2×3 then 4×4 → two wb_valid pulses with 0x06 and 0x10, each with a single start pulse.
